// File: rtl/mux_pkg.sv
// Shared widths and types for the 32:1 bit selector.
package mux_pkg;

    localparam int unsigned SEL_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/mux32_to_1_if.sv
// Select/data/valid bundle between a producer (master) and the 32:1 selector (slave).
interface mux32_to_1_if;
    import mux_pkg::*;

    sel_t  S;
    data_t I;
    logic  in_valid;
    logic  Y;
    logic  Y_q;
    logic  out_valid;

    modport master (output S, I, in_valid, input Y, Y_q, out_valid);
    modport slave  (input S, I, in_valid, output Y, Y_q, out_valid);

endinterface

// File: rtl/mux2to1.sv
// 1-bit 2:1 multiplexer; s=0 passes a (the lower-index input).
module mux2to1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux32_to_1.sv
// Picks bit I[S] from a 32-bit word through a radix-2 or radix-4 mux tree,
// with an optional registered, valid-qualified copy of the result.
module mux32_to_1 #(
    parameter int unsigned REG_OUT    = 1,
    parameter int unsigned TREE_RADIX = 2
) (
    input  logic         clk,
    input  logic         rst,
    mux32_to_1_if.slave  bus
);
    import mux_pkg::*;

    logic y_tree;

    if (TREE_RADIX != 2 && TREE_RADIX != 4) begin : g_bad_radix
        $error("mux32_to_1: TREE_RADIX must be 2 or 4");
    end

    if (TREE_RADIX == 4) begin : g_radix4
        // node[31:0] = leaves, [39:32] = first 4:1 level, [41:40] = second, [42] = root
        logic [DATA_W+10:0] node;
        assign node[DATA_W-1:0] = bus.I;

        for (genvar lv = 0; lv < 2; lv++) begin : g_lvl
            localparam int unsigned IN_OFF  = (lv == 0) ? 0 : 32;
            localparam int unsigned OUT_OFF = (lv == 0) ? 32 : 40;
            localparam int unsigned COUNT   = (lv == 0) ? 8 : 2;
            for (genvar j = 0; j < COUNT; j++) begin : g_q
                logic lo, hi;
                mux2to1 u_lo (.a(node[IN_OFF+4*j]),   .b(node[IN_OFF+4*j+1]), .s(bus.S[2*lv]),   .y(lo));
                mux2to1 u_hi (.a(node[IN_OFF+4*j+2]), .b(node[IN_OFF+4*j+3]), .s(bus.S[2*lv]),   .y(hi));
                mux2to1 u_sel(.a(lo),                 .b(hi),                 .s(bus.S[2*lv+1]), .y(node[OUT_OFF+j]));
            end
        end

        mux2to1 u_root (.a(node[40]), .b(node[41]), .s(bus.S[4]), .y(node[42]));
        assign y_tree = node[42];
    end else begin : g_radix2
        // Level k occupies node[64-(64>>k) +: 32>>k]; the root lands at node[62].
        logic [2*DATA_W-2:0] node;
        assign node[DATA_W-1:0] = bus.I;

        for (genvar lv = 0; lv < 5; lv++) begin : g_lvl
            localparam int unsigned IN_OFF  = 64 - (64 >> lv);
            localparam int unsigned OUT_OFF = 64 - (32 >> lv);
            localparam int unsigned COUNT   = 16 >> lv;
            for (genvar j = 0; j < COUNT; j++) begin : g_m
                mux2to1 u_m (.a(node[IN_OFF+2*j]), .b(node[IN_OFF+2*j+1]), .s(bus.S[lv]), .y(node[OUT_OFF+j]));
            end
        end

        assign y_tree = node[62];
    end

    assign bus.Y = y_tree;

    if (REG_OUT != 0) begin : g_reg
        logic y_q_r;
        logic valid_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                y_q_r   <= 1'b0;
                valid_r <= 1'b0;
            end else begin
                valid_r <= bus.in_valid;
                if (bus.in_valid) y_q_r <= y_tree;
            end
        end

        assign bus.Y_q       = y_q_r;
        assign bus.out_valid = valid_r;
    end else begin : g_noreg
        assign bus.Y_q       = 1'b0;
        assign bus.out_valid = 1'b0;
    end

endmodule

// File: tb/tb_mux32_to_1.sv
// Scoreboard bench driving radix-2 and radix-4 selectors with identical stimulus.
module tb_mux32_to_1;

    typedef struct packed {
        logic v;
        logic yq;
    } reg_exp_t;

    logic clk;
    logic rst;

    mux32_to_1_if bus2 ();
    mux32_to_1_if bus4 ();

    mux32_to_1 #(.REG_OUT(1), .TREE_RADIX(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mux32_to_1 #(.REG_OUT(1), .TREE_RADIX(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic     y_exp_q[$];
    reg_exp_t r_exp_q[$];
    logic     m_yq;
    int       checks;
    int       errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the selected bit is simply the data word shifted down by the index.
    task automatic apply(input logic r, input logic v, input logic [4:0] s, input logic [31:0] d);
        logic     bit_sel;
        reg_exp_t e;
        rst           = r;
        bus2.in_valid = v;
        bus4.in_valid = v;
        bus2.S        = s;
        bus4.S        = s;
        bus2.I        = d;
        bus4.I        = d;
        bit_sel = 1'((d >> s) & 32'd1);
        y_exp_q.push_back(bit_sel);
        if (r) begin
            m_yq = 1'b0;
            e.v  = 1'b0;
        end else if (v) begin
            m_yq = bit_sel;
            e.v  = 1'b1;
        end else begin
            e.v  = 1'b0;
        end
        e.yq = m_yq;
        r_exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (y_exp_q.size() > 0) begin
            logic e;
            e = y_exp_q.pop_front();
            chk("Y_radix2", bus2.Y, e);
            chk("Y_radix4", bus4.Y, e);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (r_exp_q.size() > 0) begin
                reg_exp_t e;
                e = r_exp_q.pop_front();
                chk("out_valid_radix2", bus2.out_valid, e.v);
                chk("out_valid_radix4", bus4.out_valid, e.v);
                chk("Y_q_radix2", bus2.Y_q, e.yq);
                chk("Y_q_radix4", bus4.Y_q, e.yq);
            end
        end
    end

    initial begin
        logic [31:0] d;
        int          drain;
        checks        = 0;
        errors        = 0;
        m_yq          = 1'b0;
        rst           = 1'b1;
        bus2.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        bus2.S        = '0;
        bus4.S        = '0;
        bus2.I        = '0;
        bus4.I        = '0;
        @(posedge clk);
        #2;

        apply(1'b1, 1'b0, 5'd0, 32'd0);
        apply(1'b1, 1'b0, 5'd0, 32'd0);

        // walking one: hit then neighbour miss
        for (int k = 0; k < 32; k++) begin
            d = 32'd1 << k;
            apply(1'b0, 1'b1, 5'(k), d);
            apply(1'b0, 1'b1, 5'((k + 1) % 32), d);
        end

        // walking zero: selected bit low, a sweep of other indices high
        for (int k = 0; k < 32; k++) begin
            d = ~(32'd1 << k);
            apply(1'b0, 1'b0, 5'(k), d);
            apply(1'b0, 1'b1, 5'((k + 7) % 32), d);
        end
        for (int s = 0; s < 32; s++) apply(1'b0, 1'b1, 5'(s), ~(32'd1 << 13));

        for (int s = 0; s < 32; s++) apply(1'b0, 1'b1, 5'(s), 32'hA5A5_0F0F);

        for (int k = 0; k <= 8; k++) apply(1'b0, 1'b1, 5'(k), 32'(k));

        // reset dominates valid, then release, then hold
        apply(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
        apply(1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF);
        apply(1'b0, 1'b1, 5'd9, 32'hFFFF_FFFF);
        apply(1'b0, 1'b0, 5'd9, 32'h0000_0000);
        apply(1'b0, 1'b0, 5'd3, 32'h0000_0000);

        for (int n = 0; n < 1000; n++) begin
            apply(($urandom_range(99) < 5) ? 1'b1 : 1'b0,
                  1'($urandom_range(1)),
                  5'($urandom_range(31)),
                  32'($urandom));
        end

        drain = 0;
        while ((y_exp_q.size() > 0 || r_exp_q.size() > 0) && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (y_exp_q.size() > 0 || r_exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d Y and %0d registered expectations left, expected 0",
                     y_exp_q.size(), r_exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
